// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers one instruction for
// decode, and follows execute-stage redirects while keeping an outstanding
// memory request stable until the memory answers.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         IsBranchTaken,
    input  logic [31:0]  BranchPC,
    fetch_unit_if.master imem,
    input  logic         InstrReady,
    output logic [31:0]  Instr,
    output logic [31:0]  InstrPC,
    output logic         InstrValid,
    output logic [15:0]  RedirectCount
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] reqAddr;
    logic [31:0] reqAddrNext;
    logic [31:0] branchTarget;
    logic        reqOut;
    logic        load;
    logic [31:0] loadAddr;

    // Masking keeps the redirect target word aligned.
    assign branchTarget = BranchPC & 32'hFFFF_FFFC;

    // Next-state, PC update and memory request decode.
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        reqAddrNext = reqAddr;
        reqOut      = 1'b0;
        imem.imem_addr = pc;
        load        = 1'b0;
        loadAddr    = pc;

        case (state)
            IDLE: begin
                stateNext = ISSUE;
            end
            ISSUE: begin
                reqOut = (!InstrValid || InstrReady) && !IsBranchTaken;
                if (reqOut) begin
                    if (imem.imem_ready) begin
                        load     = 1'b1;
                        loadAddr = pc;
                        pcNext   = pc + 32'd4;
                    end else begin
                        stateNext   = WAIT;
                        reqAddrNext = pc;
                    end
                end
            end
            WAIT: begin
                reqOut         = 1'b1;
                imem.imem_addr = reqAddr;
                if (IsBranchTaken) begin
                    stateNext = imem.imem_ready ? ISSUE : DRAIN;
                end else if (imem.imem_ready) begin
                    load      = 1'b1;
                    loadAddr  = reqAddr;
                    pcNext    = reqAddr + 32'd4;
                    stateNext = ISSUE;
                end
            end
            DRAIN: begin
                reqOut         = 1'b1;
                imem.imem_addr = reqAddr;
                if (imem.imem_ready) begin
                    stateNext = ISSUE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // A redirect overrides any sequential PC advance in the same cycle.
        if (IsBranchTaken) begin
            pcNext = branchTarget;
        end

        imem.imem_req = reqOut;
    end

    // State, PC and held request address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            reqAddr <= RESET_PC;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            reqAddr <= reqAddrNext;
        end
    end

    // Single-entry instruction buffer toward decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Instr      <= '0;
            InstrPC    <= '0;
            InstrValid <= 1'b0;
        end else if (load) begin
            Instr      <= imem.imem_rdata;
            InstrPC    <= loadAddr;
            InstrValid <= 1'b1;
        end else if (IsBranchTaken || (InstrValid && InstrReady)) begin
            InstrValid <= 1'b0;
        end
    end

    // Saturating count of taken redirects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RedirectCount <= '0;
        end else if (IsBranchTaken && (RedirectCount != 16'hFFFF)) begin
            RedirectCount <= RedirectCount + 16'd1;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (bits [1:0] SHALL be zero).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 IsBranchTaken  input  1  redirect request from the execute stage, sampled each cycle.
REQ-005 BranchPC  input  32  redirect target from the execute stage.
REQ-006 imem_req  output  1  instruction memory request valid.
REQ-007 imem_addr  output  32  instruction memory word address.
REQ-008 imem_ready  input  1  memory response valid; may assert in the same cycle as imem_req.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-010 InstrReady  input  1  decode stage accepts the buffered instruction.
REQ-011 Instr  output  32  buffered instruction to decode.
REQ-012 InstrPC  output  32  PC of Instr.
REQ-013 InstrValid  output  1  Instr/InstrPC valid.
REQ-014 RedirectCount  output  16  number of taken redirects since reset, saturating at 16'hFFFF.

Function
REQ-015 State machine states: IDLE, ISSUE, WAIT, DRAIN; the reset state SHALL be IDLE.
REQ-016 IDLE: imem_req=0; next state SHALL be ISSUE unconditionally.
REQ-017 ISSUE: imem_req=1 iff (!InstrValid || InstrReady) and IsBranchTaken=0; imem_addr=PC.
REQ-018 ISSUE with request and imem_ready=1: load buffer, PC<=PC+4, stay ISSUE; with request and imem_ready=0: go to WAIT.
REQ-019 WAIT: imem_req=1, imem_addr held at the issued PC; on imem_ready=1, load buffer, PC<=PC+4, go to ISSUE.
REQ-020 Buffer load: Instr<=imem_rdata, InstrPC<=issued address, InstrValid<=1.
REQ-021 Handshake: InstrValid && InstrReady SHALL consume the buffer; a load in the same cycle replaces it (InstrValid stays 1), otherwise InstrValid<=0.
REQ-022 Instr/InstrPC SHALL remain stable while InstrValid=1 and InstrReady=0.
REQ-023 Once asserted, imem_req and imem_addr SHALL NOT change until imem_ready=1, including across a redirect.
REQ-024 Redirect (IsBranchTaken=1): PC<={BranchPC[31:2],2'b00}; InstrValid<=0 next cycle; any response returned in that cycle SHALL be discarded.
REQ-025 Redirect in WAIT with imem_ready=0: go to DRAIN; in WAIT with imem_ready=1, or in ISSUE: go to ISSUE.
REQ-026 DRAIN: imem_req=1 at the held address; on imem_ready=1, discard the data without changing the PC and go to ISSUE.
REQ-027 Redirect in DRAIN: update the PC to the new target; stay in DRAIN unless imem_ready=1.
REQ-028 Redirect in IDLE: update the PC; next state remains ISSUE.
REQ-029 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-030 RedirectCount SHALL increment once per cycle with IsBranchTaken=1 and hold at 16'hFFFF.
REQ-031 A redirect has priority over PC+4 when both occur in the same cycle.

Reset
REQ-032 reset_n=0 SHALL immediately force: state=IDLE, PC=RESET_PC, InstrValid=0, Instr=0, InstrPC=0, RedirectCount=0, imem_req=0.
REQ-033 Reset asserted mid-WAIT or mid-DRAIN SHALL abandon the outstanding request; the memory is reset by the same reset_n.

Verification
REQ-034 Streaming: zero-latency memory, InstrReady=1 -> InstrPC sequence 0,4,8,12 on consecutive cycles starting 2 cycles after reset release.
REQ-035 Backpressure: InstrReady=0 for 3 cycles with Instr=32'hA5A5_0001 -> Instr/InstrPC held and imem_req=0 until accepted.
REQ-036 Redirect in WAIT: memory latency 3, IsBranchTaken=1 with BranchPC=32'h0000_0103 -> DRAIN, stale data dropped, next request at 32'h0000_0100, RedirectCount=1.
REQ-037 Simultaneous redirect and imem_ready: response for 0x8 discarded, InstrValid=0, next fetch at BranchPC.
REQ-038 Wrap: RESET_PC=32'hFFFF_FFF8 -> InstrPC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Async reset asserted mid-WAIT between clock edges -> imem_req=0 and InstrValid=0 immediately; fetch restarts at RESET_PC.
